// File: rtl/note_track_pkg.sv
// note_track_pkg: shared slot record, FSM encoding and lane geometry for the note engine
package note_track_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, LATCH, SPAWN, WAIT, MOVE, DONE} state_t;
  typedef struct packed {
    logic       valid;
    logic [1:0] lane;
    logic [9:0] ypos;
  } slot_t;
  function automatic logic [10:0] lane_x(input logic [1:0] lane, input int x0, input int pitch);
    return 11'(x0 + int'(lane) * pitch);
  endfunction
endpackage

// File: rtl/note_track_engine_if.sv
// note_track_engine_if: chart ROM, frame timing and pixel query bundle of the note engine
interface note_track_engine_if #(parameter int CHART_LEN = 21, parameter int LANES = 4);
  localparam int AW = CHART_LEN > 1 ? $clog2(CHART_LEN) : 1;
  logic             start;
  logic             screenEnd;
  logic [AW-1:0]    chart_addr;
  logic [LANES-1:0] chart_data;
  logic [9:0]       x;
  logic [8:0]       y;
  logic             in_note;
  logic [1:0]       note_lane;
  logic             playing;
  logic             done;
  logic             overflow;
  modport master (output start, screenEnd, chart_data, x, y,
                  input chart_addr, in_note, note_lane, playing, done, overflow);
  modport slave (input start, screenEnd, chart_data, x, y,
                 output chart_addr, in_note, note_lane, playing, done, overflow);
endinterface

// File: rtl/note_hit_check.sv
// note_hit_check: box test of one pixel against one slot's note rectangle
module note_hit_check
  import note_track_pkg::*;
#(
  parameter int NOTE_W     = 50,
  parameter int NOTE_H     = 20,
  parameter int LANE_X0    = 170,
  parameter int LANE_PITCH = 80
) (
  input  slot_t      i_slot,
  input  logic [9:0] i_x,
  input  logic [8:0] i_y,
  output logic       o_hit
);
  logic [10:0] w_x0, w_x, w_y, w_y0;
  assign w_x0  = lane_x(i_slot.lane, LANE_X0, LANE_PITCH);
  assign w_x   = {1'b0, i_x};
  assign w_y   = {2'b0, i_y};
  assign w_y0  = {1'b0, i_slot.ypos};
  assign o_hit = i_slot.valid && w_x >= w_x0 && w_x < w_x0 + 11'(NOTE_W)
              && w_y >= w_y0 && w_y < w_y0 + 11'(NOTE_H);
endmodule

// File: rtl/note_track_engine.sv
// note_track_engine: walks the note chart, spawns and advances falling notes, answers pixel hits
module note_track_engine
  import note_track_pkg::*;
#(
  parameter int MAX_NOTES    = 8,
  parameter int LANES        = 4,
  parameter int CHART_LEN    = 21,
  parameter int SPAWN_FRAMES = 120,
  parameter int NOTE_SPEED   = 1,
  parameter int NOTE_W       = 50,
  parameter int NOTE_H       = 20,
  parameter int LANE_X0      = 170,
  parameter int LANE_PITCH   = 80,
  parameter int VIDEO_HEIGHT = 480
) (
  input logic               clk,
  input logic               reset,
  note_track_engine_if.slave bus
);
  localparam int AW = CHART_LEN > 1 ? $clog2(CHART_LEN) : 1;
  localparam int EW = $clog2(CHART_LEN + 1);
  localparam int FW = SPAWN_FRAMES > 1 ? $clog2(SPAWN_FRAMES) : 1;
  localparam int SW = MAX_NOTES > 1 ? $clog2(MAX_NOTES) : 1;
  state_t               r_state, w_next;
  slot_t                r_slot [MAX_NOTES];
  logic [EW-1:0]        r_entry;
  logic [FW-1:0]        r_frame;
  logic [LANES-1:0]     r_pend;
  logic                 r_se, r_tick, r_pending, r_overflow, r_in_note;
  logic [1:0]           r_note_lane;
  logic [MAX_NOTES-1:0] w_hit, w_valid;
  logic [10:0]          w_ypos [MAX_NOTES];
  logic                 w_free_any, w_go, w_frame_end, w_restart;
  logic [SW-1:0]        w_free_idx;
  logic [1:0]           w_spawn_lane, w_hit_lane;
  for (genvar g = 0; g < MAX_NOTES; g++) begin : g_hit
    note_hit_check #(.NOTE_W(NOTE_W), .NOTE_H(NOTE_H), .LANE_X0(LANE_X0), .LANE_PITCH(LANE_PITCH)) u_hit (
      .i_slot(r_slot[g]), .i_x(bus.x), .i_y(bus.y), .o_hit(w_hit[g])
    );
    assign w_valid[g] = r_slot[g].valid;
    assign w_ypos[g]  = {1'b0, r_slot[g].ypos} + 11'(NOTE_SPEED);
  end
  assign w_go        = r_tick | r_pending;
  assign w_frame_end = r_frame == FW'(SPAWN_FRAMES - 1);
  assign w_restart   = bus.start && (r_state == IDLE || r_state == DONE);
  // Descending loops leave the lowest matching index as the winner.
  always_comb begin
    w_free_any   = 1'b0;
    w_free_idx   = '0;
    w_spawn_lane = '0;
    w_hit_lane   = '0;
    for (int i = MAX_NOTES - 1; i >= 0; i--) begin
      if (!r_slot[i].valid) begin
        w_free_any = 1'b1;
        w_free_idx = SW'(i);
      end
      if (w_hit[i]) w_hit_lane = r_slot[i].lane;
    end
    for (int i = LANES - 1; i >= 0; i--)
      if (r_pend[i]) w_spawn_lane = 2'(i);
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: w_next = bus.start ? FETCH : r_state;
      FETCH:      w_next = LATCH;
      LATCH:      w_next = SPAWN;
      SPAWN:      w_next = r_pend == '0 ? WAIT : SPAWN;
      WAIT:       w_next = w_go ? MOVE : (r_entry == EW'(CHART_LEN) && w_valid == '0) ? DONE : WAIT;
      MOVE:       w_next = (w_frame_end && r_entry < EW'(CHART_LEN)) ? FETCH : WAIT;
      default:    w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_se        <= 1'b0;
      r_tick      <= 1'b0;
      r_pending   <= 1'b0;
      r_entry     <= '0;
      r_frame     <= '0;
      r_pend      <= '0;
      r_overflow  <= 1'b0;
      r_in_note   <= 1'b0;
      r_note_lane <= '0;
      for (int i = 0; i < MAX_NOTES; i++) r_slot[i] <= '0;
    end else begin
      r_se        <= bus.screenEnd;
      r_tick      <= bus.screenEnd & ~r_se;
      r_pending   <= r_state == WAIT ? 1'b0 : (r_pending | r_tick);
      r_in_note   <= |w_hit;
      r_note_lane <= w_hit_lane;
      if (w_restart) begin
        r_entry <= '0;
        r_frame <= '0;
      end
      if (r_state == LATCH) r_pend <= bus.chart_data;
      if (r_state == SPAWN) begin
        if (r_pend == '0) r_entry <= r_entry + 1'b1;
        else begin
          r_pend[w_spawn_lane] <= 1'b0;
          if (w_free_any) r_slot[w_free_idx] <= '{valid: 1'b1, lane: w_spawn_lane, ypos: '0};
          else            r_overflow <= 1'b1;
        end
      end
      if (r_state == MOVE) begin
        r_frame <= w_frame_end ? '0 : r_frame + 1'b1;
        for (int i = 0; i < MAX_NOTES; i++)
          if (r_slot[i].valid) begin
            r_slot[i].ypos  <= w_ypos[i][9:0];
            r_slot[i].valid <= w_ypos[i] < 11'(VIDEO_HEIGHT);
          end
      end
    end
  end
  assign bus.chart_addr = r_entry[AW-1:0];
  assign bus.in_note    = r_in_note;
  assign bus.note_lane  = r_note_lane;
  assign bus.playing    = r_state != IDLE && r_state != DONE;
  assign bus.done       = r_state == DONE;
  assign bus.overflow   = r_overflow;
endmodule

// File: tb/tb_note_track_engine.sv
// tb_note_track_engine: directed checks of spawn, move, retire, overflow, done and pixel queries
module tb_note_track_engine;
  import note_track_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic se = 1'b0;
  int total = 0;
  int bad = 0;
  logic [3:0] chart_a [32];
  logic [3:0] chart_b [32];
  logic [3:0] chart_c [2];
  always #5 clk = ~clk;
  note_track_engine_if #(.CHART_LEN(21)) ia ();
  note_track_engine_if #(.CHART_LEN(21)) ib ();
  note_track_engine_if #(.CHART_LEN(2))  ic ();
  assign ia.screenEnd = se;
  assign ib.screenEnd = se;
  assign ic.screenEnd = se;
  always_ff @(posedge clk) begin
    ia.chart_data <= chart_a[ia.chart_addr];
    ib.chart_data <= chart_b[ib.chart_addr];
    ic.chart_data <= chart_c[ic.chart_addr];
  end
  note_track_engine dut_a (.clk(clk), .reset(reset), .bus(ia.slave));
  note_track_engine #(.MAX_NOTES(4), .SPAWN_FRAMES(2)) dut_b (.clk(clk), .reset(reset), .bus(ib.slave));
  note_track_engine #(.CHART_LEN(2), .SPAWN_FRAMES(2), .NOTE_SPEED(240)) dut_c (.clk(clk), .reset(reset), .bus(ic.slave));

  task automatic do_reset();
    reset = 1'b0;
    se = 1'b0;
    ia.start = 1'b0; ib.start = 1'b0; ic.start = 1'b0;
    for (int i = 0; i < 32; i++) begin chart_a[i] = '0; chart_b[i] = '0; end
    chart_c[0] = '0; chart_c[1] = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic pulse_start(input int s);
    @(posedge clk); #1;
    ia.start = s == 0; ib.start = s == 1; ic.start = s == 2;
    @(posedge clk); #1;
    ia.start = 1'b0; ib.start = 1'b0; ic.start = 1'b0;
  endtask

  task automatic tick();
    se = 1'b1;
    repeat (3) @(posedge clk);
    #1 se = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic query_a(input logic [9:0] qx, input logic [8:0] qy);
    ia.x = qx; ia.y = qy;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (ia.in_note !== 1'b0) begin bad++; $display("FAIL rst_in_note got %0b want 0", ia.in_note); end
    total++; if (ia.note_lane !== 2'd0) begin bad++; $display("FAIL rst_note_lane got %0d want 0", ia.note_lane); end
    total++; if ({ia.playing, ia.done, ia.overflow} !== 3'b000) begin bad++; $display("FAIL rst_flags got %b want 000", {ia.playing, ia.done, ia.overflow}); end
    total++; if (ia.chart_addr !== 5'd0) begin bad++; $display("FAIL rst_chart_addr got %0d want 0", ia.chart_addr); end
    total++; if (dut_a.r_state !== IDLE) begin bad++; $display("FAIL rst_state got %0d want IDLE", dut_a.r_state); end
    repeat (3) tick();
    total++; if (dut_a.w_valid !== 8'h00) begin bad++; $display("FAIL idle_ticks_valid got %h want 00", dut_a.w_valid); end
    total++; if (dut_a.r_state !== IDLE || ia.playing !== 1'b0) begin bad++; $display("FAIL idle_ticks_state got %0d/%0b want IDLE/0", dut_a.r_state, ia.playing); end
  endtask

  task automatic test_single_note();
    do_reset();
    chart_a[0] = 4'b0001;
    pulse_start(0);
    repeat (3) @(posedge clk);
    #1;
    total++; if (dut_a.r_slot[0] !== slot_t'{1'b1, 2'd0, 10'd0}) begin bad++; $display("FAIL spawn_slot0 got %h want %h", dut_a.r_slot[0], slot_t'{1'b1, 2'd0, 10'd0}); end
    total++; if (dut_a.r_slot[1].valid !== 1'b0) begin bad++; $display("FAIL spawn_slot1 got %0b want 0", dut_a.r_slot[1].valid); end
    total++; if (ia.playing !== 1'b1) begin bad++; $display("FAIL spawn_playing got %0b want 1", ia.playing); end
    repeat (10) tick();
    total++; if (dut_a.r_slot[0].ypos !== 10'd10) begin bad++; $display("FAIL move10_ypos got %0d want 10", dut_a.r_slot[0].ypos); end
    query_a(10'd170, 9'd12);
    total++; if ({ia.in_note, ia.note_lane} !== 3'b100) begin bad++; $display("FAIL q_170_12 got %b want 100", {ia.in_note, ia.note_lane}); end
    query_a(10'd220, 9'd12);
    total++; if (ia.in_note !== 1'b0) begin bad++; $display("FAIL q_220_12 got %0b want 0", ia.in_note); end
    query_a(10'd219, 9'd29);
    total++; if (ia.in_note !== 1'b1) begin bad++; $display("FAIL q_219_29 got %0b want 1", ia.in_note); end
    query_a(10'd170, 9'd30);
    total++; if (ia.in_note !== 1'b0) begin bad++; $display("FAIL q_170_30 got %0b want 0", ia.in_note); end
    query_a(10'd170, 9'd9);
    total++; if (ia.in_note !== 1'b0) begin bad++; $display("FAIL q_170_9 got %0b want 0", ia.in_note); end
  endtask

  task automatic test_four_lanes();
    do_reset();
    chart_a[0] = 4'b1111;
    pulse_start(0);
    repeat (3) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (dut_a.r_slot[i] !== slot_t'{1'b1, 2'(i), 10'd0}) begin bad++; $display("FAIL alloc_slot%0d got %h want %h", i, dut_a.r_slot[i], slot_t'{1'b1, 2'(i), 10'd0}); end
      if (i < 3) begin
        total++; if (dut_a.r_slot[i+1].valid !== 1'b0) begin bad++; $display("FAIL alloc_early%0d got 1 want 0", i + 1); end
      end
      @(posedge clk);
    end
    #1;
    total++; if (ia.overflow !== 1'b0) begin bad++; $display("FAIL alloc_overflow got %0b want 0", ia.overflow); end
    query_a(10'd410, 9'd5);
    total++; if ({ia.in_note, ia.note_lane} !== 3'b111) begin bad++; $display("FAIL q_lane3 got %b want 111", {ia.in_note, ia.note_lane}); end
    query_a(10'd249, 9'd5);
    total++; if (ia.in_note !== 1'b0) begin bad++; $display("FAIL q_gap got %0b want 0", ia.in_note); end
    query_a(10'd250, 9'd0);
    total++; if ({ia.in_note, ia.note_lane} !== 3'b101) begin bad++; $display("FAIL q_lane1 got %b want 101", {ia.in_note, ia.note_lane}); end
  endtask

  task automatic test_overflow();
    do_reset();
    chart_b[0] = 4'b1111;
    chart_b[1] = 4'b1111;
    pulse_start(1);
    repeat (8) @(posedge clk);
    #1;
    total++; if ({ib.overflow, dut_b.w_valid} !== 5'b0_1111) begin bad++; $display("FAIL ovf_first got %b want 01111", {ib.overflow, dut_b.w_valid}); end
    tick();
    tick();
    repeat (6) @(posedge clk);
    #1;
    total++; if (ib.overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got %0b want 1", ib.overflow); end
    total++; if (dut_b.w_valid !== 4'hF) begin bad++; $display("FAIL ovf_pool got %h want F", dut_b.w_valid); end
    total++; if (ib.chart_addr !== 5'd2) begin bad++; $display("FAIL ovf_entry got %0d want 2", ib.chart_addr); end
    total++; if (dut_b.r_slot[3].ypos !== 10'd2) begin bad++; $display("FAIL ovf_ypos got %0d want 2", dut_b.r_slot[3].ypos); end
  endtask

  task automatic test_retire();
    do_reset();
    chart_a[0] = 4'b0001;
    pulse_start(0);
    repeat (6) @(posedge clk);
    #1;
    repeat (479) tick();
    total++; if (dut_a.r_slot[0] !== slot_t'{1'b1, 2'd0, 10'd479}) begin bad++; $display("FAIL ret_479 got %h want %h", dut_a.r_slot[0], slot_t'{1'b1, 2'd0, 10'd479}); end
    query_a(10'd170, 9'd479);
    total++; if (ia.in_note !== 1'b1) begin bad++; $display("FAIL ret_q_before got %0b want 1", ia.in_note); end
    tick();
    total++; if (dut_a.r_slot[0].valid !== 1'b0) begin bad++; $display("FAIL ret_valid got %0b want 0", dut_a.r_slot[0].valid); end
    query_a(10'd170, 9'd479);
    total++; if (ia.in_note !== 1'b0) begin bad++; $display("FAIL ret_q_after got %0b want 0", ia.in_note); end
  endtask

  task automatic test_done_and_tick();
    do_reset();
    chart_c[0] = 4'b0011;
    chart_c[1] = 4'b0001;
    pulse_start(2);
    @(posedge clk);
    #1 se = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    total++; if (dut_c.r_slot[0] !== slot_t'{1'b1, 2'd0, 10'd240}) begin bad++; $display("FAIL spawn_tick_s0 got %h want %h", dut_c.r_slot[0], slot_t'{1'b1, 2'd0, 10'd240}); end
    total++; if (dut_c.r_slot[1] !== slot_t'{1'b1, 2'd1, 10'd240}) begin bad++; $display("FAIL spawn_tick_s1 got %h want %h", dut_c.r_slot[1], slot_t'{1'b1, 2'd1, 10'd240}); end
    se = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tick();
    tick();
    total++; if (dut_c.r_slot[0] !== slot_t'{1'b1, 2'd0, 10'd240}) begin bad++; $display("FAIL entry1_s0 got %h want %h", dut_c.r_slot[0], slot_t'{1'b1, 2'd0, 10'd240}); end
    total++; if (dut_c.r_slot[1].valid !== 1'b0) begin bad++; $display("FAIL entry1_s1 got %0b want 0", dut_c.r_slot[1].valid); end
    total++; if ({ic.playing, ic.done} !== 2'b10) begin bad++; $display("FAIL pre_done got %b want 10", {ic.playing, ic.done}); end
    tick();
    total++; if ({ic.playing, ic.done} !== 2'b01) begin bad++; $display("FAIL done got %b want 01", {ic.playing, ic.done}); end
    query_a(10'd0, 9'd0);
    total++; if ({ic.playing, ic.done} !== 2'b01) begin bad++; $display("FAIL done_sticky got %b want 01", {ic.playing, ic.done}); end
    pulse_start(2);
    total++; if ({ic.playing, ic.done, ic.chart_addr} !== 3'b100) begin bad++; $display("FAIL restart got %b want 100", {ic.playing, ic.done, ic.chart_addr}); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    chart_a[0] = 4'b1111;
    pulse_start(0);
    repeat (8) @(posedge clk);
    #1;
    total++; if (dut_a.w_valid !== 8'h0F) begin bad++; $display("FAIL mid_pre got %h want 0F", dut_a.w_valid); end
    se = 1'b1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    total++; if (dut_a.w_valid !== 8'h00) begin bad++; $display("FAIL mid_valid got %h want 00", dut_a.w_valid); end
    total++; if ({ia.playing, dut_a.r_pending, dut_a.r_tick} !== 3'b000) begin bad++; $display("FAIL mid_flags got %b want 000", {ia.playing, dut_a.r_pending, dut_a.r_tick}); end
    se = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (dut_a.r_state !== IDLE) begin bad++; $display("FAIL mid_state got %0d want IDLE", dut_a.r_state); end
  endtask

  initial begin
    ia.x = '0; ia.y = '0; ib.x = '0; ib.y = '0; ic.x = '0; ic.y = '0;
    ia.start = 1'b0; ib.start = 1'b0; ic.start = 1'b0;
    test_reset();
    test_single_note();
    test_four_lanes();
    test_overflow();
    test_retire();
    test_done_and_tick();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/note_track_engine.md
Name: note_track_engine

Overview:
- Upstream of the VGA controller: owns every falling note on the play field.
- Walks a note chart, spawns notes into a fixed slot pool, and advances them once per video frame.
- Answers the per-pixel question "is (x,y) inside a note, and in which lane" for the colour mux.
- Replaces the single hard-wired note register and the free-running spawn and move clocks with one synchronous, clk-domain engine.

Parameters:
- MAX_NOTES, 8: slot pool size (power of 2).
- LANES, 4: lane count; chart entry width.
- CHART_LEN, 21: number of chart entries.
- SPAWN_FRAMES, 120: frames between chart entries (2 s at 60 Hz).
- NOTE_SPEED, 1: pixels per frame.
- NOTE_W, 50: note width, pixels.
- NOTE_H, 20: note height, pixels.
- LANE_X0, 170: x of lane 0 left edge.
- LANE_PITCH, 80: x spacing between lanes.
- VIDEO_HEIGHT, 480: retire threshold.

Ports:
- clk  in  1  100 MHz system clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; begins chart playback from entry 0.
- screenEnd  in  1  frame boundary level from the timing generator; the block rising-edge detects it internally.
- chart_addr  out  $clog2(CHART_LEN)  chart ROM address.
- chart_data  in  LANES  chart ROM data, valid 1 cycle after chart_addr; bit i set = note in lane i.
- x  in  10  pixel x.
- y  in  9  pixel y.
- in_note  out  1  pixel is inside a live note; registered.
- note_lane  out  2  lane of the hit note; lowest slot index wins.
- playing  out  1  high from start until done.
- done  out  1  chart exhausted and all slots empty; sticky until start or reset.
- overflow  out  1  sticky; a spawn found no free slot.

Behaviour:
- Reset (reset==0 at posedge clk): all slots invalid; state IDLE.
- Reset output values: chart_addr=0, in_note=0, note_lane=0, playing=0, done=0, overflow=0.
- Frame tick: screenEnd rising edge is registered → frame_tick, a 1-cycle pulse. A tick arriving outside WAIT sets tick_pending; tick_pending is consumed on the next WAIT cycle. At most one pending tick; extra ticks are lost.
- Slot contents: valid, lane[1:0], ypos[9:0].
- FSM states:
  - IDLE: start → FETCH with entry=0, frame_cnt=0, playing=1, done=0. start in any other state is ignored.
  - FETCH: drive chart_addr=entry; next cycle → LATCH.
  - LATCH: pend_mask <= chart_data → SPAWN.
  - SPAWN: one lane per cycle, lowest set bit of pend_mask first. Allocate the lowest-index invalid slot with ypos=0 and clear that bit. No free slot → set overflow, drop that lane's note, clear the bit. pend_mask==0 → WAIT; entry increments.
  - WAIT, on tick or tick_pending → MOVE.
  - WAIT, otherwise: if entry==CHART_LEN and no valid slot → DONE.
  - MOVE (1 cycle, all slots in parallel): ypos += NOTE_SPEED, in 11-bit arithmetic. A slot whose new ypos ≥ VIDEO_HEIGHT is invalidated the same cycle. frame_cnt increments.
  - MOVE exit: frame_cnt reaches SPAWN_FRAMES-1 and entry<CHART_LEN → frame_cnt=0, FETCH. Otherwise → WAIT.
  - DONE: playing=0, done=1; start → FETCH.
- An all-zero chart entry spawns nothing but still consumes its spawn period.
- Pixel query, 1-cycle latency from x,y. A slot hits when:
  - valid, and
  - LANE_X0+lane*LANE_PITCH ≤ x < that value + NOTE_W, and
  - ypos ≤ y < ypos+NOTE_H.
- in_note = OR of slot hits. note_lane = lane of the lowest-index hitting slot, else 0.
- The pixel query runs in every state, including DONE, and never stalls the FSM.
- Reset mid-operation clears everything within one cycle; a pending tick is discarded.

Decomposition:
- Shared package (note_track_pkg):
  - slot record fields and widths;
  - FSM state encoding (IDLE, FETCH, LATCH, SPAWN, WAIT, MOVE, DONE);
  - lane x-origin function.
- Sub-module note_hit_check: one slot's box compare. Instantiated MAX_NOTES times via generate; reuses the existing bounds-check style.

Test Plan:
- Reset held 3 cycles, then released → all outputs 0, state IDLE. screenEnd toggling without start → no slot becomes valid.
- Chart[0]=4'b0001, start → slot0 valid, lane 0, ypos=0 after FETCH+LATCH+1 SPAWN cycle. After 10 ticks, ypos=10. Query x=170,y=12 → in_note=1, note_lane=0 one cycle later. Query x=220,y=12 → in_note=0.
- Chart[0]=4'b1111 → slots 0-3 allocated in lane order 0,1,2,3 over 4 consecutive cycles. overflow stays 0.
- MAX_NOTES=4, two consecutive 4'b1111 entries, SPAWN_FRAMES=2 → second entry finds no free slot. overflow=1, pool still holds 4 notes.
- Note at ypos=479, one tick → slot invalidated the same MOVE cycle. Query y=479 next cycle → in_note=0.
- CHART_LEN=2, SPAWN_FRAMES=2, NOTE_SPEED=240 → done=1 and playing=0 once both notes retire. Tick during SPAWN → MOVE still occurs exactly once after SPAWN.
